// File: rtl/led_column_scroller_pkg.sv
// Shared types for the LED column scroller: window geometry, column/frame types
// and the scroll state machine encoding.
package led_pkg;

    localparam int unsigned MEM_LEN = 16;

    typedef logic [7:0] led_col_t;
    typedef led_col_t led_frame_t [MEM_LEN];

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_SHIFT = 1'b1
    } scroll_state_t;

    localparam led_col_t BLANK_COL = 8'h00;

endpackage

// File: rtl/led_column_scroller_fifo.sv
// Synchronous column FIFO with flush; power-of-two depth so pointers wrap naturally.
module led_col_fifo
    import led_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  led_col_t                   i_push_data,
    input  logic                       i_pop,
    output led_col_t                   o_pop_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    led_col_t        r_store [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_store[r_rd_ptr];

    // Full blocks push even if a pop happens in the same cycle.
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_store[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/led_column_scroller.sv
// 16-byte LED display window fed from a column FIFO; shifts left one byte per
// scroll tick so text or graphics marquee without processor involvement.
module led_column_scroller
    import led_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned SCROLL_DELAY = 5_000_000,
    parameter int unsigned EMPTY_MODE   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          col_valid,
    input  logic [7:0]                    col_data,
    output logic                          col_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          shifted,
    output led_frame_t                    mem
);

    localparam int unsigned      TW     = $clog2(SCROLL_DELAY);
    localparam logic [TW-1:0]    RELOAD = TW'(SCROLL_DELAY - 1);

    logic [TW-1:0]   r_timer;
    scroll_state_t   r_state;
    scroll_state_t   w_state_next;
    led_frame_t      r_window;

    logic            w_tick;
    logic            w_do_shift;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    led_col_t        w_fifo_head;
    led_col_t        w_new_col;
    logic            w_shifted;

    led_col_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (clear),
        .i_push      (w_push),
        .i_push_data (col_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (fifo_count)
    );

    assign col_ready = !w_fifo_full;
    assign w_push    = col_valid && col_ready && !clear;

    assign w_tick     = enable && (r_timer == '0);
    // Emptiness is sampled in the tick cycle, so a same-cycle push is not seen.
    assign w_do_shift = w_tick && !clear && (!w_fifo_empty || (EMPTY_MODE == 0));
    assign w_pop      = w_do_shift && !w_fifo_empty;
    assign w_new_col  = w_fifo_empty ? BLANK_COL : w_fifo_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= RELOAD;
        end else if (clear) begin
            r_timer <= RELOAD;
        end else if (enable) begin
            r_timer <= w_tick ? RELOAD : (r_timer - TW'(1));
        end
    end

    // The window and FIFO update on the tick edge; S_SHIFT marks the cycle in
    // which the new window is visible, which gives the 1-clock tick latency.
    always_comb begin
        w_state_next = S_WAIT;
        w_shifted    = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_state_next = w_do_shift ? S_SHIFT : S_WAIT;
            end
            S_SHIFT: begin
                w_shifted    = 1'b1;
                w_state_next = w_do_shift ? S_SHIFT : S_WAIT;
            end
            default: begin
                w_state_next = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAIT;
        end else if (clear) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_window <= '{default: BLANK_COL};
        end else if (clear) begin
            r_window <= '{default: BLANK_COL};
        end else if (w_do_shift) begin
            for (int unsigned i = 0; i < MEM_LEN - 1; i++) begin
                r_window[i] <= r_window[i + 1];
            end
            r_window[MEM_LEN - 1] <= w_new_col;
        end
    end

    assign shifted = w_shifted;
    assign mem     = r_window;

endmodule

// File: tb/tb_led_column_scroller.sv
// Directed bench for led_column_scroller with SCROLL_DELAY=4, FIFO_DEPTH=4;
// one instance per EMPTY_MODE.
module tb_led_column_scroller;
    import led_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        en0 = 1'b0, clr0 = 1'b0, val0 = 1'b0;
    logic [7:0]  dat0 = 8'h00;
    logic        rdy0, sh0;
    logic [2:0]  cnt0;
    led_frame_t  mem0;

    logic        en1 = 1'b0, clr1 = 1'b0, val1 = 1'b0;
    logic [7:0]  dat1 = 8'h00;
    logic        rdy1, sh1;
    logic [2:0]  cnt1;
    led_frame_t  mem1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_column_scroller #(
        .FIFO_DEPTH   (4),
        .SCROLL_DELAY (4),
        .EMPTY_MODE   (0)
    ) dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (en0),
        .clear      (clr0),
        .col_valid  (val0),
        .col_data   (dat0),
        .col_ready  (rdy0),
        .fifo_count (cnt0),
        .shifted    (sh0),
        .mem        (mem0)
    );

    led_column_scroller #(
        .FIFO_DEPTH   (4),
        .SCROLL_DELAY (4),
        .EMPTY_MODE   (1)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .enable     (en1),
        .clear      (clr1),
        .col_valid  (val1),
        .col_data   (dat1),
        .col_ready  (rdy1),
        .fifo_count (cnt1),
        .shifted    (sh1),
        .mem        (mem1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four clocks from a timer reload: shifted must appear only on the fourth.
    task automatic wait_tick0(input string tag);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq(tag, sh0, (k == 4));
        end
    endtask

    function automatic logic [7:0] or_all(input led_frame_t m);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 16; i++) acc = acc | m[i];
        return acc;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] words [5];
        logic       seen;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;

        // Reset and release
        repeat (2) step();
        reset = 1'b1;
        check_eq("rst_mem",   or_all(mem0), 8'h00);
        check_eq("rst_ready", rdy0, 1'b1);
        check_eq("rst_count", cnt0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("rst_idle_shifted", sh0, 1'b0);
        end

        // Two pushes, then three ticks (third one on an empty FIFO)
        val0 = 1'b1; dat0 = 8'hA1; step();
        dat0 = 8'hB2; step();
        val0 = 1'b0;
        check_eq("push2_count", cnt0, 3'd2);
        en0 = 1'b1;
        wait_tick0("t1_shifted");
        check_eq("t1_mem15", mem0[15], 8'hA1);
        check_eq("t1_mem14", mem0[14], 8'h00);
        check_eq("t1_count", cnt0, 3'd1);
        wait_tick0("t2_shifted");
        check_eq("t2_mem14", mem0[14], 8'hA1);
        check_eq("t2_mem15", mem0[15], 8'hB2);
        check_eq("t2_count", cnt0, 3'd0);
        wait_tick0("t3_shifted");
        check_eq("t3_mem13", mem0[13], 8'hA1);
        check_eq("t3_mem14", mem0[14], 8'hB2);
        check_eq("t3_mem15", mem0[15], 8'h00);
        check_eq("t3_count", cnt0, 3'd0);
        en0 = 1'b0;

        // EMPTY_MODE=1: one real shift, then empty ticks stall
        val1 = 1'b1; dat1 = 8'h5C; step();
        val1 = 1'b0;
        check_eq("em1_count", cnt1, 3'd1);
        en1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq("em1_shifted", sh1, (k == 4));
        end
        check_eq("em1_mem15", mem1[15], 8'h5C);
        seen = 1'b0;
        repeat (12) begin
            step();
            seen = seen | sh1;
        end
        check_eq("em1_stall_shifted", seen, 1'b0);
        check_eq("em1_stall_mem15", mem1[15], 8'h5C);
        check_eq("em1_stall_mem14", mem1[14], 8'h00);
        en1 = 1'b0;

        // Overfill: fifth word refused
        for (int i = 0; i < 5; i++) begin
            val0 = 1'b1; dat0 = words[i];
            check_eq("fill_ready", rdy0, (i < 4));
            step();
        end
        val0 = 1'b0;
        check_eq("full_count", cnt0, 3'd4);
        check_eq("full_ready", rdy0, 1'b0);
        en0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_tick0("drain_shifted");
            check_eq("drain_mem15", mem0[15], words[k]);
            check_eq("drain_count", cnt0, 3'(3 - k));
        end
        check_eq("drain_order_mem12", mem0[12], 8'h11);
        check_eq("drain_ready", rdy0, 1'b1);

        // clear coincident with a tick and a push
        val0 = 1'b1; dat0 = 8'h66; step();
        val0 = 1'b0; step();
        step();
        check_eq("preclr_count", cnt0, 3'd1);
        clr0 = 1'b1; val0 = 1'b1; dat0 = 8'h77;
        step();
        clr0 = 1'b0; val0 = 1'b0;
        check_eq("clr_mem", or_all(mem0), 8'h00);
        check_eq("clr_count", cnt0, 3'd0);
        check_eq("clr_shifted", sh0, 1'b0);
        wait_tick0("clr_next_tick");
        check_eq("clr_tick_mem15", mem0[15], 8'h00);
        check_eq("clr_tick_count", cnt0, 3'd0);

        // Reset asserted during the shifted cycle
        val0 = 1'b1; dat0 = 8'h9D; step();
        dat0 = 8'h9E; step();
        val0 = 1'b0; step();
        step();
        check_eq("pre_rst_shifted", sh0, 1'b1);
        check_eq("pre_rst_mem15", mem0[15], 8'h9D);
        check_eq("pre_rst_count", cnt0, 3'd1);
        reset = 1'b0;
        #1;
        check_eq("async_rst_shifted", sh0, 1'b0);
        check_eq("async_rst_mem", or_all(mem0), 8'h00);
        check_eq("async_rst_count", cnt0, 3'd0);
        check_eq("async_rst_ready", rdy0, 1'b1);
        step();
        step();
        reset = 1'b1;
        wait_tick0("post_rst_tick");
        check_eq("post_rst_mem15", mem0[15], 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
